// File: rtl/radar_seq_pkg.sv
// Shared types, limits and config validation for the radar CPI sequencer.
package radar_seq_pkg;

  localparam int unsigned FFT_SIZE     = 1024;
  localparam int unsigned DOPPLER_SIZE = 64;
  localparam int unsigned CNT_WIDTH    = 32;
  localparam int unsigned IDX_WIDTH    = 16;

  typedef enum logic [2:0] {
    IDLE,
    PULSE,
    DOPPLER,
    CFAR,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic [CNT_WIDTH-1:0] pri;
    logic [CNT_WIDTH-1:0] pw;
    logic [IDX_WIDTH-1:0] gates;
    logic [IDX_WIDTH-1:0] pulses;
  } seq_cfg_t;

  // A CPI needs a non-empty TX gate, a listen phase after it, and bounded gate/pulse counts.
  function automatic logic cfg_valid(input seq_cfg_t cfg);
    return (cfg.pw != '0) && (cfg.pri > cfg.pw) &&
           (cfg.gates != '0) && (cfg.gates <= IDX_WIDTH'(FFT_SIZE)) &&
           (cfg.pulses != '0) && (cfg.pulses <= IDX_WIDTH'(DOPPLER_SIZE));
  endfunction

endpackage

// File: rtl/radar_pri_timer.sv
// PRI counter with TX gate / RX window decode and an end-of-PRI strobe.
module radar_pri_timer
  import radar_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 clear,
  input  logic [CNT_WIDTH-1:0] pri,
  input  logic [CNT_WIDTH-1:0] pw,
  input  logic [IDX_WIDTH-1:0] gate_idx,
  input  logic [IDX_WIDTH-1:0] num_gates,
  output logic                 tx_pulse,
  output logic                 rx_window,
  output logic                 end_of_pri
);

  logic [CNT_WIDTH-1:0] pri_cnt;

  assign end_of_pri = run && (pri_cnt == pri - CNT_WIDTH'(1));
  assign tx_pulse   = run && (pri_cnt < pw);
  assign rx_window  = run && (pri_cnt >= pw) && (gate_idx < num_gates);

  // Held at zero outside PULSE so every pulse starts from a clean count.
  always_ff @(posedge clk) begin
    if (rst || !run || clear || end_of_pri) begin
      pri_cnt <= '0;
    end else begin
      pri_cnt <= pri_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/radar_cpi_sequencer.sv
// CPI sequencer: pulse train with range gating, then Doppler and CFAR handshakes.
module radar_cpi_sequencer
  import radar_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 continuous,
  input  logic [CNT_WIDTH-1:0] cfg_pri,
  input  logic [CNT_WIDTH-1:0] cfg_pulse_width,
  input  logic [IDX_WIDTH-1:0] cfg_num_gates,
  input  logic [IDX_WIDTH-1:0] cfg_num_pulses,
  input  logic                 rx_valid,
  input  logic                 doppler_done,
  input  logic                 cfar_done,
  output logic                 tx_pulse,
  output logic                 rx_window,
  output logic                 sample_strobe,
  output logic [IDX_WIDTH-1:0] gate_idx,
  output logic [IDX_WIDTH-1:0] pulse_idx,
  output logic                 last_gate,
  output logic                 doppler_start,
  output logic                 cfar_start,
  output logic                 busy,
  output logic                 cpi_done,
  output logic                 overrun_err,
  output logic                 cfg_err
);

  seq_state_t state_q, state_d;
  seq_cfg_t   cfg_q, cfg_in;
  logic       accept, reject, restart;
  logic       in_pulse, pulse_step, last_pulse, end_of_pri;

  assign cfg_in = '{pri: cfg_pri, pw: cfg_pulse_width, gates: cfg_num_gates, pulses: cfg_num_pulses};

  assign in_pulse      = (state_q == PULSE);
  assign pulse_step    = in_pulse && !abort;
  assign busy          = (state_q != IDLE);
  assign last_pulse    = (pulse_idx == cfg_q.pulses - IDX_WIDTH'(1));
  assign sample_strobe = rx_valid && rx_window;
  assign last_gate     = sample_strobe && (gate_idx == cfg_q.gates - IDX_WIDTH'(1));
  assign restart       = (state_q == DONE) && (state_d == PULSE);

  radar_pri_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .run        (in_pulse),
    .clear      (abort),
    .pri        (cfg_q.pri),
    .pw         (cfg_q.pw),
    .gate_idx   (gate_idx),
    .num_gates  (cfg_q.gates),
    .tx_pulse   (tx_pulse),
    .rx_window  (rx_window),
    .end_of_pri (end_of_pri)
  );

  // Next-state decode; the start strobes double as "entry cycle" markers so done is
  // only honoured from the cycle after the kick.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (cfg_valid(cfg_in)) begin
            accept  = 1'b1;
            state_d = PULSE;
          end else begin
            reject = 1'b1;
          end
        end
      end
      PULSE: begin
        if (abort) state_d = IDLE;
        else if (end_of_pri && last_pulse) state_d = DOPPLER;
      end
      DOPPLER: begin
        if (abort) state_d = IDLE;
        else if (doppler_done && !doppler_start) state_d = CFAR;
      end
      CFAR: begin
        if (abort) state_d = IDLE;
        else if (cfar_done && !cfar_start) state_d = DONE;
      end
      DONE:    state_d = (continuous && !abort) ? PULSE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cfg_q         <= '0;
      gate_idx      <= '0;
      pulse_idx     <= '0;
      overrun_err   <= 1'b0;
      doppler_start <= 1'b0;
      cfar_start    <= 1'b0;
      cpi_done      <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      state_q       <= state_d;
      doppler_start <= (state_q == PULSE) && (state_d == DOPPLER);
      cfar_start    <= (state_q == DOPPLER) && (state_d == CFAR);
      cpi_done      <= (state_q == CFAR) && (state_d == DONE);
      cfg_err       <= reject;

      if (accept) cfg_q <= cfg_in;

      if (accept) begin
        overrun_err <= 1'b0;
      end else if (pulse_step && end_of_pri && (gate_idx < cfg_q.gates)) begin
        overrun_err <= 1'b1;
      end

      // Gate index saturates naturally: the RX window closes once all gates are in.
      if (accept || restart) begin
        gate_idx  <= '0;
        pulse_idx <= '0;
      end else if (pulse_step) begin
        if (end_of_pri) begin
          gate_idx <= '0;
          if (!last_pulse) pulse_idx <= pulse_idx + IDX_WIDTH'(1);
        end else if (sample_strobe) begin
          gate_idx <= gate_idx + IDX_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_radar_cpi_sequencer.sv
// Scoreboard bench for radar_cpi_sequencer: expected events are queued at stimulus time.
`timescale 1ns/1ps
module tb_radar_cpi_sequencer;
  import radar_seq_pkg::*;

  localparam int EV_TX   = 0;
  localparam int EV_STB  = 1;
  localparam int EV_LAST = 2;
  localparam int EV_DST  = 3;
  localparam int EV_CST  = 4;
  localparam int EV_DONE = 5;
  localparam int EV_CERR = 6;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic                 continuous = 1'b0;
  logic [CNT_WIDTH-1:0] cfg_pri = '0;
  logic [CNT_WIDTH-1:0] cfg_pulse_width = '0;
  logic [IDX_WIDTH-1:0] cfg_num_gates = '0;
  logic [IDX_WIDTH-1:0] cfg_num_pulses = '0;
  logic                 rx_valid = 1'b1;
  logic                 doppler_done = 1'b0;
  logic                 cfar_done = 1'b0;
  logic                 tx_pulse, rx_window, sample_strobe, last_gate;
  logic [IDX_WIDTH-1:0] gate_idx, pulse_idx;
  logic                 doppler_start, cfar_start, busy, cpi_done, overrun_err, cfg_err;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          tx_high = 0;
  logic        tx_prev = 1'b0;
  logic [63:0] q_ev[7][$];

  int bad_pri[5]    = '{20, 20, 20, 20, 20};
  int bad_pw[5]     = '{0, 4, 20, 4, 4};
  int bad_gates[5]  = '{8, 8, 8, 0, 1025};
  int bad_pulses[5] = '{3, 65, 3, 3, 3};

  radar_cpi_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .continuous      (continuous),
    .cfg_pri         (cfg_pri),
    .cfg_pulse_width (cfg_pulse_width),
    .cfg_num_gates   (cfg_num_gates),
    .cfg_num_pulses  (cfg_num_pulses),
    .rx_valid        (rx_valid),
    .doppler_done    (doppler_done),
    .cfar_done       (cfar_done),
    .tx_pulse        (tx_pulse),
    .rx_window       (rx_window),
    .sample_strobe   (sample_strobe),
    .gate_idx        (gate_idx),
    .pulse_idx       (pulse_idx),
    .last_gate       (last_gate),
    .doppler_start   (doppler_start),
    .cfar_start      (cfar_start),
    .busy            (busy),
    .cpi_done        (cpi_done),
    .overrun_err     (overrun_err),
    .cfg_err         (cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ev(input int c, input int p, input int g);
    return {32'(c), 16'(p), 16'(g)};
  endfunction

  task automatic see(input int k, input string tag, input logic [63:0] got);
    check({tag, "_expected"}, 64'(q_ev[k].size() != 0), 64'd1);
    if (q_ev[k].size() != 0) check(tag, got, q_ev[k].pop_front());
  endtask

  // Event monitor: every DUT event must match the head of its scoreboard queue.
  always @(negedge clk) begin
    if (tx_pulse) tx_high++;
    if (tx_pulse && !tx_prev) see(EV_TX, "tx_rise", ev(cyc, 0, 0));
    if (sample_strobe) see(EV_STB, "strobe", ev(cyc, int'(pulse_idx), int'(gate_idx)));
    if (last_gate) see(EV_LAST, "last_gate", ev(cyc, int'(pulse_idx), int'(gate_idx)));
    if (doppler_start) see(EV_DST, "doppler_start", ev(cyc, 0, 0));
    if (cfar_start) see(EV_CST, "cfar_start", ev(cyc, 0, 0));
    if (cpi_done) see(EV_DONE, "cpi_done", ev(cyc, 0, 0));
    if (cfg_err) see(EV_CERR, "cfg_err", ev(cyc, 0, 0));
    tx_prev = tx_pulse;
  end

  // Doppler / CFAR stage stand-ins: done 10 and 5 cycles after their kicks.
  initial begin
    forever begin
      @(negedge clk);
      if (doppler_start) begin
        repeat (10) @(posedge clk);
        #1 doppler_done = 1'b1;
        @(posedge clk);
        #1 doppler_done = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cfar_start) begin
        repeat (5) @(posedge clk);
        #1 cfar_done = 1'b1;
        @(posedge clk);
        #1 cfar_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_start(input int pri, input int pw, input int gates, input int pulses,
                             output int s);
    @(posedge clk);
    #1;
    s               = cyc;
    cfg_pri         = CNT_WIDTH'(pri);
    cfg_pulse_width = CNT_WIDTH'(pw);
    cfg_num_gates   = IDX_WIDTH'(gates);
    cfg_num_pulses  = IDX_WIDTH'(pulses);
    start           = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic push_cpi(input int s, input int pri, input int pw, input int gates, input int pulses);
    int n;
    n = (gates < pri - pw) ? gates : pri - pw;
    for (int p = 0; p < pulses; p++) begin
      q_ev[EV_TX].push_back(ev(s + 1 + p * pri, 0, 0));
      for (int g = 0; g < n; g++) q_ev[EV_STB].push_back(ev(s + 1 + p * pri + pw + g, p, g));
      if (gates <= pri - pw) q_ev[EV_LAST].push_back(ev(s + pw + p * pri + gates, p, gates - 1));
    end
    q_ev[EV_DST].push_back(ev(s + 1 + pulses * pri, 0, 0));
    q_ev[EV_CST].push_back(ev(s + 12 + pulses * pri, 0, 0));
    q_ev[EV_DONE].push_back(ev(s + 18 + pulses * pri, 0, 0));
  endtask

  task automatic check_drained(input string tag);
    for (int k = 0; k < 7; k++) begin
      check($sformatf("%s_drained_%0d", tag, k), 64'(q_ev[k].size()), 64'd0);
      q_ev[k].delete();
    end
  endtask

  task automatic run_cpi(input int pri, input int pw, input int gates, input int pulses, input int ncpi);
    int   s, t0, len;
    logic exp_ovr;
    len        = pulses * pri + 18;
    exp_ovr    = (gates > pri - pw);
    continuous = (ncpi > 1);
    rx_valid   = 1'b1;
    t0         = tx_high;
    drive_start(pri, pw, gates, pulses, s);
    for (int k = 0; k < ncpi; k++) push_cpi(s + k * len, pri, pw, gates, pulses);
    // Live inputs change and an invalid start arrives mid-CPI: both must be ignored.
    cfg_pulse_width = '0;
    cfg_pri         = CNT_WIDTH'(3);
    cfg_num_pulses  = IDX_WIDTH'(99);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (cyc < s + pri) @(negedge clk);
    check("ovr_before_eop", 64'(overrun_err), 64'd0);
    @(negedge clk);
    check("ovr_after_eop", 64'(overrun_err), 64'(exp_ovr));
    if (ncpi > 1) begin
      while (cyc < s + len + 1) @(negedge clk);
      check("cont_tx", 64'(tx_pulse), 64'd1);
      check("cont_pidx", 64'(pulse_idx), 64'd0);
      continuous = 1'b0;
    end
    for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
    check("idle_reached", 64'(busy), 64'd0);
    check("idle_cycle", 64'(cyc), 64'(s + ncpi * len + 1));
    check("ovr_final", 64'(overrun_err), 64'(exp_ovr));
    check("tx_cycles", 64'(tx_high - t0), 64'(ncpi * pulses * pw));
    repeat (4) @(negedge clk);
    check_drained("cpi");
  endtask

  initial begin
    int s, t0;

    // Reset state, with rx_valid high to show the strobe stays gated.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 64'(tx_pulse), 64'd0);
    check("rst_rxw", 64'(rx_window), 64'd0);
    check("rst_strobe", 64'(sample_strobe), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_gate", 64'(gate_idx), 64'd0);
    check("rst_pulse", 64'(pulse_idx), 64'd0);
    check("rst_flags", 64'({doppler_start, cfar_start, cpi_done, overrun_err, cfg_err}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    run_cpi(20, 4, 8, 3, 1);
    run_cpi(20, 4, 30, 2, 1);

    // Invalid configs: one cfg_err pulse, never busy, overrun untouched.
    for (int i = 0; i < 5; i++) begin
      t0 = tx_high;
      drive_start(bad_pri[i], bad_pw[i], bad_gates[i], bad_pulses[i], s);
      q_ev[EV_CERR].push_back(ev(s + 1, 0, 0));
      @(negedge clk);
      check($sformatf("bad%0d_busy", i), 64'(busy), 64'd0);
      check($sformatf("bad%0d_ovr", i), 64'(overrun_err), 64'd1);
      repeat (2) @(negedge clk);
      check($sformatf("bad%0d_busy_late", i), 64'(busy), 64'd0);
      check($sformatf("bad%0d_tx", i), 64'(tx_high - t0), 64'd0);
      check_drained("bad");
    end

    // Largest legal config is accepted; abort keeps the overrun it raised.
    rx_valid = 1'b1;
    drive_start(2, 1, 1024, 64, s);
    for (int p = 0; p < 3; p++) q_ev[EV_TX].push_back(ev(s + 1 + 2 * p, 0, 0));
    for (int p = 0; p < 2; p++) q_ev[EV_STB].push_back(ev(s + 2 + 2 * p, p, 0));
    @(negedge clk);
    check("max_busy", 64'(busy), 64'd1);
    check("max_ovr_clear", 64'(overrun_err), 64'd0);
    repeat (2) @(negedge clk);
    check("max_ovr_set", 64'(overrun_err), 64'd1);
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("max_abort_busy", 64'(busy), 64'd0);
    check("max_abort_ovr", 64'(overrun_err), 64'd1);
    repeat (5) @(negedge clk);
    check_drained("max");

    // Abort during pulse 1: everything drops next cycle, no Doppler kick ever.
    drive_start(20, 4, 8, 3, s);
    q_ev[EV_TX].push_back(ev(s + 1, 0, 0));
    q_ev[EV_TX].push_back(ev(s + 21, 0, 0));
    for (int g = 0; g < 8; g++) q_ev[EV_STB].push_back(ev(s + 5 + g, 0, g));
    q_ev[EV_LAST].push_back(ev(s + 12, 0, 7));
    q_ev[EV_STB].push_back(ev(s + 25, 1, 0));
    repeat (24) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_tx", 64'(tx_pulse), 64'd0);
    check("abort_rxw", 64'(rx_window), 64'd0);
    check("abort_ovr_cleared", 64'(overrun_err), 64'd0);
    repeat (80) @(negedge clk);
    check_drained("abort");
    run_cpi(20, 4, 8, 3, 1);

    run_cpi(20, 4, 8, 3, 2);

    // Reset in the middle of the RX window.
    drive_start(20, 4, 8, 3, s);
    q_ev[EV_TX].push_back(ev(s + 1, 0, 0));
    for (int g = 0; g < 4; g++) q_ev[EV_STB].push_back(ev(s + 5 + g, 0, g));
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mrst_tx", 64'(tx_pulse), 64'd0);
    check("mrst_rxw", 64'(rx_window), 64'd0);
    check("mrst_strobe", 64'(sample_strobe), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_gate", 64'(gate_idx), 64'd0);
    check("mrst_pulse", 64'(pulse_idx), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (80) @(negedge clk);
    check_drained("mrst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
